// File: rtl/regfile_dump_reader.sv
// Purpose : debug read-out engine that walks an inclusive register index range on a spare
//           register-file read port and streams (index, value) pairs out.
// Latency : first word presented 3 cycles after the start cycle; 1 word/cycle while out_ready stays high.
// Backpr. : valid/ready on the output; the presented word holds stable while out_ready is low.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start/start_addr/end_addr dump request, sampled only when idle
//   abort                    ends a dump in progress; done still pulses
//   halt_req                 core must not write the register file while high
//   rd_addr/rd_data          register-file read port (combinational read)
//   out_valid/out_ready/out_addr/out_data/out_last  streamed words
//   busy, done, err          status: engine active, completion pulse, bad-range pulse
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic                  abort,
    output logic                  halt_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIESCE,
        S_LOAD,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   end_q, end_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    xfer;

    assign xfer = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            end_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            end_q       <= end_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        end_d       = end_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_addr <= end_addr) begin
                        ptr_d   = start_addr;
                        end_d   = end_addr;
                        state_d = S_QUIESCE;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            // One dead cycle so a writeback already in flight lands before the
            // first read; the register file has no write-to-read bypass.
            S_QUIESCE: begin
                if (abort) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FINISH;
                    done_d      = 1'b1;
                end else begin
                    out_data_d  = rd_data;
                    out_addr_d  = ptr_q;
                    ptr_d       = ptr_q + ADDR_WIDTH'(1);
                    out_valid_d = 1'b1;
                    state_d     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FINISH;
                    done_d      = 1'b1;
                end else if (xfer) begin
                    // End test on the presented index, not ptr: ptr has already
                    // wrapped to 0 when the range ends at the top register.
                    if (out_addr_q == end_q) begin
                        out_valid_d = 1'b0;
                        state_d     = S_FINISH;
                        done_d      = 1'b1;
                    end else begin
                        out_data_d = rd_data;
                        out_addr_d = ptr_q;
                        ptr_d      = ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign halt_req  = (state_q == S_QUIESCE) || (state_q == S_LOAD) ||
                       (state_q == S_STREAM)  || (state_q == S_FINISH);
    assign busy      = (state_q != S_IDLE);
    assign rd_addr   = ptr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_valid_q && (out_addr_q == end_q);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Purpose : scoreboard bench for regfile_dump_reader against a behavioural register file.
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpr. : out_ready driven from fixed levels or a toggle pattern.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  start_addr;
    logic [4:0]  end_addr;
    logic        abort;
    logic        halt_req;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] regs [32];

    // {last, addr, data}
    logic [37:0] sb [$];
    logic [37:0] exp_w;

    int checks;
    int failures;

    logic        hold_q;
    logic [4:0]  hold_addr;
    logic [31:0] hold_data;

    logic [5:0]  rdy_pat;

    regfile_dump_reader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .abort      (abort),
        .halt_req   (halt_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // x0 is hardwired to zero
    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Output monitor: pops the scoreboard on every transfer and checks hold stability.
    always @(negedge clk) begin
        if (hold_q) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_addr", 64'(out_addr), 64'(hold_addr));
            chk("hold_data", 64'(out_data), 64'(hold_data));
        end
        chk("halt_eq_busy", 64'(halt_req), 64'(busy));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_word", 64'(out_addr), 64'h100);
            end else begin
                exp_w = sb.pop_front();
                chk("word_addr", 64'(out_addr), 64'(exp_w[36:32]));
                chk("word_data", 64'(out_data), 64'(exp_w[31:0]));
                chk("word_last", 64'(out_last), 64'(exp_w[37]));
            end
        end
        hold_q    = out_valid && !out_ready && !rst;
        hold_addr = out_addr;
        hold_data = out_data;
    end

    task automatic push_range(input int s, input int e);
        for (int i = s; i <= e; i++) begin
            logic [31:0] v;
            v = (i == 0) ? 32'd0 : regs[i];
            sb.push_back({(i == e), 5'(i), v});
        end
    endtask

    // Returns at posedge+1 of the cycle after the start edge.
    task automatic start_dump(input int s, input int e);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 5'(s);
        end_addr   = 5'(e);
        if (s <= e) push_range(s, e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, then checks the FINISH/IDLE tail of the dump.
    task automatic wait_done(input string tag, input bit toggle, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (toggle) out_ready = rdy_pat[c % 6];
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_halt_in_finish"}, 64'(halt_req), 64'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_halt_fall"}, 64'(halt_req), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        chk({tag, "_valid_low"}, 64'(out_valid), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        checks     = 0;
        failures   = 0;
        hold_q     = 1'b0;
        hold_addr  = '0;
        hold_data  = '0;
        rdy_pat    = 6'b101001;  // bit c: 1,0,0,1,0,1
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'h11111111;
        regs[2] = 32'h22222222;
        regs[3] = 32'h33333333;
        regs[5] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_halt", 64'(halt_req), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Scenario 1: range 1..3, ready held high, cycle-accurate timing
        start_dump(1, 3);
        @(negedge clk);
        chk("s1_halt_rise", 64'(halt_req), 64'd1);
        chk("s1_quiesce_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("s1_load_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("s1_first_valid", 64'(out_valid), 64'd1);
        chk("s1_first_addr", 64'(out_addr), 64'd1);
        @(negedge clk);
        chk("s1_second_addr", 64'(out_addr), 64'd2);
        @(negedge clk);
        chk("s1_third_addr", 64'(out_addr), 64'd3);
        chk("s1_third_last", 64'(out_last), 64'd1);
        wait_done("s1", 1'b0, 20);

        // Scenario 2: same range, ready toggling
        start_dump(1, 3);
        wait_done("s2", 1'b1, 40);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Scenario 3: single-word range
        start_dump(5, 5);
        wait_done("s3", 1'b0, 20);

        // Scenario 4: illegal range
        start_dump(7, 3);
        @(negedge clk);
        chk("s4_err", 64'(err), 64'd1);
        chk("s4_done", 64'(done), 64'd1);
        chk("s4_busy", 64'(busy), 64'd0);
        chk("s4_halt", 64'(halt_req), 64'd0);
        chk("s4_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("s4_err_pulse", 64'(err), 64'd0);
        chk("s4_done_pulse", 64'(done), 64'd0);
        chk("s4_busy_after", 64'(busy), 64'd0);

        // Scenario 5: full range with wrap of the read pointer
        for (int n = 1; n < 32; n++) regs[n] = 32'(n) * 32'h01010101;
        start_dump(0, 31);
        wait_done("s5", 1'b0, 100);
        repeat (3) @(negedge clk);
        chk("s5_no_33rd", 64'(out_valid), 64'd0);

        // Scenario 6a: abort together with the transfer of index 4
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 5'd0;
        end_addr   = 5'd31;
        push_range(0, 4);
        sb[4][37]  = 1'b0;  // index 4 is not the range end
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == 5'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("s6_reach_idx3", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("s6_abort_idx", 64'(out_addr), 64'd4);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("s6_abort_valid", 64'(out_valid), 64'd0);
        chk("s6_abort_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("s6_abort_done_once", 64'(done), 64'd0);
        chk("s6_abort_idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("s6_abort_no_more", 64'(out_valid), 64'd0);
        chk("s6_abort_sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();

        // Scenario 6b: reset during STREAM with the first word held
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start_dump(0, 31);
        sb.delete();  // partial dump is discarded; nothing transfers
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("s6_rst_reach_stream", 64'(found), 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s6_rst_valid", 64'(out_valid), 64'd0);
        chk("s6_rst_halt", 64'(halt_req), 64'd0);
        chk("s6_rst_busy", 64'(busy), 64'd0);
        chk("s6_rst_done", 64'(done), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6_rst_stays_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
